host_specific_top_tx_to_host: RTL and testbench

Return path of the host-specific top level. Accepts one 144-bit Bluetooth packet from the radio side and checks its framing. Decrypts the 16-bit payload with the one-time-pad key unless passthrough is active, then streams a 5-byte UART response frame to the host over a valid/ready byte handshake. It is the counterpart of the host-to-radio command path and shares its packet format and passthrough flag.

---
 rtl/host_specific_top_tx_to_host.sv | 163 ++++++++++++++++
 tb/tb_host_specific_top_tx_to_host.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/host_specific_top_tx_to_host.sv
// Radio-to-host return path: checks the framing of one received BLE packet, optionally
// removes the one-time pad, then streams a 5-byte UART frame over a valid/ready byte handshake.
module host_specific_top_tx_to_host #(
  parameter logic [15:0] OTP_KEY        = 16'hA5C3,
  parameter int          TIMEOUT_CYCLES = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [143:0] packet_in,
  input  logic         packet_valid,
  input  logic         encrypt_decrypt_passthrough,
  output logic         packet_ready,
  output logic [7:0]   tx_byte,
  output logic         tx_valid,
  input  logic         tx_ready,
  output logic         done,
  output logic         error
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CHECK   = 2'd1,
    S_DECRYPT = 2'd2,
    S_SEND    = 2'd3
  } state_t;

  localparam int            TW      = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  state_t        r_state, w_next_state;
  logic [15:0]   r_sync, r_payload, r_data;
  logic [3:0]    r_cmd;
  logic [7:0]    r_check;
  logic          r_pt;
  logic [2:0]    r_idx;
  logic [TW-1:0] r_timeout;
  logic          r_packet_ready, r_tx_valid, r_done, r_error;
  logic [7:0]    r_tx_byte;

  logic          w_xfer, w_frame_ok, w_timeout, w_last;
  logic [15:0]   w_data;
  logic [7:0]    w_tx_byte_n;
  logic          w_error_n;
  logic          w_unused;

  assign w_unused = ^{packet_in[123:120], packet_in[95:0]};

  function automatic logic [7:0] frame_byte(input logic [2:0] idx, input logic [3:0] cmd,
                                            input logic [15:0] data);
    case (idx)
      3'd0:    frame_byte = 8'h7E;
      3'd1:    frame_byte = {4'h0, cmd};
      3'd2:    frame_byte = data[15:8];
      3'd3:    frame_byte = data[7:0];
      3'd4:    frame_byte = {4'h0, cmd} ^ data[15:8] ^ data[7:0];
      default: frame_byte = 8'h00;
    endcase
  endfunction

  assign w_xfer     = (r_state == S_SEND) && r_tx_valid && tx_ready;
  assign w_last     = (r_idx == 3'd4);
  assign w_timeout  = (r_state == S_SEND) && !tx_ready && (r_timeout == TO_LAST);
  assign w_frame_ok = (r_sync == 16'hD391) && ((r_cmd == 4'h1) || (r_cmd == 4'h2)) &&
                      (r_check == (r_payload[15:8] ^ r_payload[7:0] ^ {r_cmd, 4'h0}));
  // Ack payloads and passthrough packets bypass the pad.
  assign w_data     = ((r_cmd == 4'h1) && !r_pt) ? (r_payload ^ OTP_KEY) : r_payload;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = S_IDLE;
    case (r_state)
      S_IDLE:    w_next_state = packet_valid ? S_CHECK : S_IDLE;
      S_CHECK:   w_next_state = w_frame_ok ? S_DECRYPT : S_IDLE;
      S_DECRYPT: w_next_state = S_SEND;
      S_SEND: begin
        if (w_timeout)            w_next_state = S_IDLE;
        else if (w_xfer && w_last) w_next_state = S_IDLE;
        else                      w_next_state = S_SEND;
      end
      default:   w_next_state = S_IDLE;
    endcase
  end

  // Outputs are registered, so compute the values they take in the next cycle.
  always_comb begin
    w_tx_byte_n = 8'h00;
    if (r_state == S_DECRYPT) begin
      w_tx_byte_n = 8'h7E;
    end else if ((r_state == S_SEND) && (w_next_state == S_SEND)) begin
      w_tx_byte_n = w_xfer ? frame_byte(3'(r_idx + 3'd1), r_cmd, r_data) : r_tx_byte;
    end else begin
      w_tx_byte_n = 8'h00;
    end
    w_error_n = r_error;
    case (r_state)
      S_IDLE:    w_error_n = packet_valid ? 1'b0 : r_error;
      S_CHECK:   w_error_n = w_frame_ok ? r_error : 1'b1;
      S_DECRYPT: w_error_n = r_error;
      S_SEND:    w_error_n = w_timeout ? 1'b1 : r_error;
      default:   w_error_n = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_packet_ready <= 1'b0;
      r_tx_valid     <= 1'b0;
      r_tx_byte      <= 8'h00;
      r_done         <= 1'b0;
      r_error        <= 1'b0;
    end else begin
      r_packet_ready <= (w_next_state == S_IDLE);
      r_tx_valid     <= (w_next_state == S_SEND);
      r_tx_byte      <= w_tx_byte_n;
      r_done         <= w_xfer && w_last;
      r_error        <= w_error_n;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync    <= 16'h0000;
      r_cmd     <= 4'h0;
      r_payload <= 16'h0000;
      r_check   <= 8'h00;
      r_pt      <= 1'b0;
      r_data    <= 16'h0000;
      r_idx     <= 3'd0;
      r_timeout <= '0;
    end else begin
      if ((r_state == S_IDLE) && packet_valid) begin
        r_sync    <= packet_in[143:128];
        r_cmd     <= packet_in[127:124];
        r_payload <= packet_in[119:104];
        r_check   <= packet_in[103:96];
        r_pt      <= encrypt_decrypt_passthrough;
      end
      if (r_state == S_DECRYPT) begin
        r_data    <= w_data;
        r_idx     <= 3'd0;
        r_timeout <= '0;
      end else if (r_state == S_SEND) begin
        if (w_xfer) begin
          r_idx     <= 3'(r_idx + 3'd1);
          r_timeout <= '0;
        end else if (!tx_ready) begin
          r_timeout <= TW'(r_timeout + 1'b1);
        end
      end
    end
  end

  assign packet_ready = r_packet_ready;
  assign tx_valid     = r_tx_valid;
  assign tx_byte      = r_tx_byte;
  assign done         = r_done;
  assign error        = r_error;

endmodule

// File: tb/tb_host_specific_top_tx_to_host.sv
// Scoreboard bench: the driver pushes the expected UART frame from a packet-level model,
// a negedge monitor pops and compares each byte that transfers.
module tb_host_specific_top_tx_to_host;
  logic         clk = 1'b0;
  logic         reset;
  logic [143:0] packet_in;
  logic         packet_valid;
  logic         pt;
  logic         packet_ready;
  logic [7:0]   tx_byte;
  logic         tx_valid;
  logic         tx_ready;
  logic         done;
  logic         error;

  int         n_checks = 0;
  int         n_fail   = 0;
  int         bytes_seen = 0;
  bit         rdy_random = 1'b0;
  logic [7:0] exp_q[$];

  host_specific_top_tx_to_host dut (
    .clk(clk), .reset(reset), .packet_in(packet_in), .packet_valid(packet_valid),
    .encrypt_decrypt_passthrough(pt), .packet_ready(packet_ready), .tx_byte(tx_byte),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: framing rules and the 5-byte response frame.
  function automatic logic pkt_ok(input logic [143:0] p);
    logic [3:0] c;
    c = p[127:124];
    return (p[143:128] == 16'hD391) && (c == 4'h1 || c == 4'h2) &&
           (p[103:96] == (p[119:112] ^ p[111:104] ^ {c, 4'h0}));
  endfunction

  function automatic logic [143:0] mkpkt(input logic [3:0] cmd, input logic [15:0] pl);
    logic [7:0] ck;
    ck = pl[15:8] ^ pl[7:0] ^ {cmd, 4'h0};
    return {16'hD391, cmd, 4'($urandom), pl, ck, $urandom, $urandom, $urandom};
  endfunction

  task automatic push_frame(input logic [143:0] p, input logic ptv);
    logic [3:0]  c;
    logic [15:0] d;
    c = p[127:124];
    d = (c == 4'h1 && !ptv) ? (p[119:104] ^ 16'hA5C3) : p[119:104];
    exp_q.push_back(8'h7E);
    exp_q.push_back({4'h0, c});
    exp_q.push_back(d[15:8]);
    exp_q.push_back(d[7:0]);
    exp_q.push_back({4'h0, c} ^ d[15:8] ^ d[7:0]);
  endtask

  // Returns at accept edge + 1, i.e. inside cycle T0+1.
  task automatic accept(input logic [143:0] p, input logic ptv);
    int n;
    n = 0;
    @(negedge clk);
    while (!packet_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", packet_ready, 1);
    bytes_seen = 0;
    if (pkt_ok(p)) push_frame(p, ptv);
    packet_in = p;
    pt = ptv;
    packet_valid = 1'b1;
    @(posedge clk);
    #1;
    packet_valid = 1'b0;
    pt = 1'($urandom);
    packet_in = {$urandom, $urandom, $urandom, $urandom, 16'($urandom)};
  endtask

  task automatic wait_done(input bit timing);
    int cyc;
    bit got;
    cyc = 0;
    got = 1'b0;
    while (cyc < 400 && !got) begin
      @(negedge clk);
      cyc++;
      if (timing && cyc == 2) chk("valid_T2", tx_valid, 0);
      if (timing && cyc == 3) chk("valid_T3", tx_valid, 1);
      if (done) got = 1'b1;
    end
    chk("done_seen", got, 1);
    if (timing) chk("done_cycle", cyc, 8);
    chk("frame_consumed", exp_q.size(), 0);
    chk("error_after_good", error, 0);
    @(negedge clk);
    chk("done_pulse", done, 0);
  endtask

  task automatic chk_bad(input logic [143:0] p);
    accept(p, 1'($urandom));
    @(negedge clk);
    chk("err_cleared_T1", error, 0);
    @(negedge clk);
    chk("err_T2", error, 1);
    chk("ready_T2", packet_ready, 1);
    chk("no_valid_T2", tx_valid, 0);
  endtask

  task automatic wait_bytes(input int n);
    int k;
    k = 0;
    while (bytes_seen < n && k < 100) begin
      @(negedge clk);
      #1;
      k++;
    end
    chk("bytes_wait", (bytes_seen >= n), 1);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rdy_random) tx_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: every byte that transfers must match the head of the scoreboard.
  initial begin
    logic       prev_stall;
    logic [7:0] prev_byte;
    logic [7:0] e;
    prev_stall = 1'b0;
    prev_byte  = 8'h00;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall && tx_valid) chk("hold_byte", tx_byte, prev_byte);
        if (tx_valid && tx_ready) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_byte: got %0h expected none", tx_byte);
          end else begin
            e = exp_q.pop_front();
            chk("tx_byte", tx_byte, e);
            bytes_seen++;
          end
        end
        prev_stall = tx_valid && !tx_ready;
        prev_byte  = tx_byte;
      end
    end
  end

  initial begin
    #2000000;
    n_fail++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    logic [143:0] p;
    logic [3:0]   c;
    reset = 1'b1;
    packet_valid = 1'b0;
    packet_in = 144'h0;
    pt = 1'b0;
    tx_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_ready", packet_ready, 0);
    chk("rst_valid", tx_valid, 0);
    chk("rst_byte", tx_byte, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", packet_ready, 1);

    accept({16'hD391, 4'h1, 4'h0, 16'h1234, 8'h36, 96'h0}, 1'b0);
    wait_done(1'b1);
    accept({16'hD391, 4'h1, 4'h0, 16'h1234, 8'h36, 96'h0}, 1'b1);
    wait_done(1'b1);
    accept({16'hD391, 4'h2, 4'h0, 16'h00FF, 8'hDF, 96'h0}, 1'b0);
    wait_done(1'b1);

    chk_bad({16'hD390, 4'h1, 4'h0, 16'h1234, 8'h36, 96'h0});
    chk_bad({16'hD391, 4'h1, 4'h0, 16'h1234, 8'h37, 96'h0});
    chk_bad({16'hD391, 4'h3, 4'h0, 16'h1234, 8'h16, 96'h0});
    accept({16'hD391, 4'h1, 4'h0, 16'h1234, 8'h36, 96'h0}, 1'b0);
    wait_done(1'b1);

    // Stall after byte1; a packet offered meanwhile must be ignored.
    accept({16'hD391, 4'h1, 4'h0, 16'h1234, 8'h36, 96'h0}, 1'b0);
    wait_bytes(2);
    @(posedge clk);
    #1;
    tx_ready = 1'b0;
    packet_in = mkpkt(4'h2, 16'($urandom));
    packet_valid = 1'b1;
    repeat (10) begin
      @(negedge clk);
      chk("stall_valid", tx_valid, 1);
      chk("stall_byte", tx_byte, 8'hB7);
    end
    @(posedge clk);
    #1;
    tx_ready = 1'b1;
    packet_valid = 1'b0;
    wait_done(1'b0);

    // Timeout: 64 ready-low SEND cycles from T0+3 to T0+66.
    tx_ready = 1'b0;
    accept(mkpkt(4'h1, 16'hBEEF), 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("to_valid_T3", tx_valid, 1);
    repeat (63) @(posedge clk);
    @(negedge clk);
    chk("to_valid_last", tx_valid, 1);
    chk("to_err_last", error, 0);
    @(negedge clk);
    chk("to_valid_drop", tx_valid, 0);
    chk("to_error", error, 1);
    chk("to_ready", packet_ready, 1);
    exp_q.delete();
    tx_ready = 1'b1;
    accept(mkpkt(4'h1, 16'h0F0F), 1'b0);
    wait_done(1'b1);

    // Reset after byte2 transfer.
    accept(mkpkt(4'h1, 16'h5A5A), 1'b0);
    wait_bytes(3);
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("mid_rst_valid", tx_valid, 0);
    chk("mid_rst_ready", packet_ready, 0);
    chk("mid_rst_byte", tx_byte, 0);
    chk("mid_rst_error", error, 0);
    chk("mid_rst_done", done, 0);
    exp_q.delete();
    @(negedge clk);
    reset = 1'b0;
    accept(mkpkt(4'h2, 16'hC001), 1'b1);
    wait_done(1'b1);

    rdy_random = 1'b1;
    for (int i = 0; i < 40; i++) begin
      c = ($urandom_range(0, 4) == 0) ? 4'($urandom) : 4'($urandom_range(1, 2));
      p = mkpkt(c, 16'($urandom));
      if ($urandom_range(0, 4) == 0) p[96 + $urandom_range(0, 47)] ^= 1'b1;
      if (pkt_ok(p)) begin
        accept(p, 1'($urandom));
        wait_done(1'b0);
      end else begin
        chk_bad(p);
      end
    end
    rdy_random = 1'b0;
    tx_ready = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
